// File: rtl/bitty_uart_host_if.sv
// UART host interface for the bitty core: RX bytes -> little-endian words -> FWFT FIFO, core response words -> TX frames.
// Optional even parity on both directions when BITTY_UART_PARITY_EN is defined (default build is 8N1).
module bitty_uart_host_if #(
  parameter int CLK_DIV    = 434,
  parameter int WORD_BYTES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    rx_i,
  output logic                    tx_o,
  output logic [8*WORD_BYTES-1:0] word_o,
  output logic                    word_valid_o,
  input  logic                    word_ready_i,
  input  logic [8*WORD_BYTES-1:0] resp_i,
  input  logic                    resp_valid_i,
  output logic                    resp_ready_o,
  output logic                    frame_err_o,
  output logic                    overflow_o
);

  localparam int W    = 8 * WORD_BYTES;
  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(CLK_DIV);
  localparam int BCW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef BITTY_UART_PARITY_EN
    RX_PAR,
`endif
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef BITTY_UART_PARITY_EN
    TX_PAR,
`endif
    TX_STOP
  } tx_state_t;

  // ---------------- RX synchroniser ----------------
  logic rx_meta, rx_sync, rx_prev, rx_fall;

  // NOTE: synchroniser flops reset to the idle-high line level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // ---------------- RX FSM ----------------
  rx_state_t       rx_state, rx_next;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_mid, rx_end, byte_ok, byte_bad;
`ifdef BITTY_UART_PARITY_EN
  logic            par_bad;
`endif

  assign rx_mid = (rx_cnt == CW'(HALF));
  assign rx_end = (rx_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rx_next  = rx_state;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: begin
        if (rx_mid && rx_sync) rx_next = RX_IDLE;
        else if (rx_end)       rx_next = RX_DATA;
      end
`ifdef BITTY_UART_PARITY_EN
      RX_DATA:  if (rx_end && rx_bit == 3'd7) rx_next = RX_PAR;
      RX_PAR:   if (rx_end) rx_next = RX_STOP;
      RX_STOP: begin
        if (rx_mid) begin
          rx_next  = RX_IDLE;
          byte_ok  = rx_sync & ~par_bad;
          byte_bad = ~rx_sync | par_bad;
        end
      end
`else
      RX_DATA:  if (rx_end && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (rx_mid) begin
          rx_next  = RX_IDLE;
          byte_ok  = rx_sync;
          byte_bad = ~rx_sync;
        end
      end
`endif
      default:  rx_next = RX_IDLE;
    endcase
    if (!ena) begin
      rx_next  = RX_IDLE;
      byte_ok  = 1'b0;
      byte_bad = 1'b0;
    end
  end

  // The start-bit counter begins at 1 because the falling edge itself is bit position 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= CW'(1);
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
`ifdef BITTY_UART_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else if (rx_state == RX_IDLE) begin
      rx_cnt <= CW'(1);
      rx_bit <= 3'd0;
    end else begin
      rx_cnt <= rx_end ? '0 : rx_cnt + CW'(1);
      if (rx_state == RX_DATA && rx_mid) rx_shift <= {rx_sync, rx_shift[7:1]};
      if (rx_state == RX_DATA && rx_end) rx_bit <= rx_bit + 3'd1;
`ifdef BITTY_UART_PARITY_EN
      if (rx_state == RX_PAR && rx_mid) par_bad <= ^{rx_shift, rx_sync};
`endif
    end
  end

  // ---------------- word assembly ----------------
  logic [BCW-1:0] byte_cnt;
  logic [W-1:0]   word_buf;
  logic           push_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt     <= '0;
      word_buf     <= '0;
      push_pending <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      push_pending <= 1'b0;
      if (byte_bad) frame_err_o <= 1'b1;
      if (!ena || byte_bad) begin
        byte_cnt <= '0;
      end else if (byte_ok) begin
        word_buf[8*byte_cnt +: 8] <= rx_shift;
        if (byte_cnt == BCW'(WORD_BYTES - 1)) begin
          byte_cnt     <= '0;
          push_pending <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + BCW'(1);
        end
      end
    end
  end

  // ---------------- RX word FIFO (first-word-fall-through) ----------------
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, push_ok;

  assign full    = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop     = word_valid_o & word_ready_i;
  assign push_ok = push_pending & (~full | pop);

  // NOTE: storage is deliberately not reset; word_o is masked to zero while the FIFO is empty instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= word_buf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push_pending && full && !pop) overflow_o <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign word_valid_o = (count != '0);
  assign word_o       = word_valid_o ? mem[rd_ptr] : '0;

  // ---------------- TX FSM ----------------
  tx_state_t      tx_state, tx_next;
  logic [CW-1:0]  tx_cnt;
  logic [2:0]     tx_bit;
  logic [BCW-1:0] tx_byte;
  logic [W-1:0]   tx_word;
  logic [7:0]     cur_byte;
  logic           tx_end, tx_take;

  assign tx_end       = (tx_cnt == CW'(CLK_DIV - 1));
  assign resp_ready_o = ena & (tx_state == TX_IDLE);
  assign tx_take      = resp_valid_i & resp_ready_o;
  assign cur_byte     = tx_word[8*tx_byte +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    tx_o    = 1'b1;
    case (tx_state)
      TX_IDLE:  if (tx_take) tx_next = TX_START;
      TX_START: begin
        tx_o = 1'b0;
        if (tx_end) tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx_o = cur_byte[tx_bit];
`ifdef BITTY_UART_PARITY_EN
        if (tx_end && tx_bit == 3'd7) tx_next = TX_PAR;
      end
      TX_PAR: begin
        tx_o = ^cur_byte;
        if (tx_end) tx_next = TX_STOP;
`else
        if (tx_end && tx_bit == 3'd7) tx_next = TX_STOP;
`endif
      end
      TX_STOP: begin
        if (tx_end) tx_next = (tx_byte == BCW'(WORD_BYTES - 1)) ? TX_IDLE : TX_START;
      end
      default:  tx_next = TX_IDLE;
    endcase
    if (!ena) begin
      tx_next = TX_IDLE;
      tx_o    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt  <= '0;
      tx_bit  <= 3'd0;
      tx_byte <= '0;
      tx_word <= '0;
    end else if (tx_state == TX_IDLE) begin
      tx_cnt  <= '0;
      tx_bit  <= 3'd0;
      tx_byte <= '0;
      if (tx_take) tx_word <= resp_i;
    end else begin
      tx_cnt <= tx_end ? '0 : tx_cnt + CW'(1);
      if (tx_state == TX_DATA && tx_end) tx_bit  <= tx_bit + 3'd1;
      if (tx_state == TX_STOP && tx_end) tx_byte <= tx_byte + BCW'(1);
    end
  end

endmodule

// File: tb/tb_bitty_uart_host_if.sv
// Directed bench for bitty_uart_host_if (CLK_DIV=4, WORD_BYTES=2, FIFO_DEPTH=4).
// Define BITTY_UART_PARITY_EN for both bench and RTL to exercise the parity build.
module tb_bitty_uart_host_if;

  localparam int CLK_DIV    = 4;
  localparam int WORD_BYTES = 2;
  localparam int FIFO_DEPTH = 4;
`ifdef BITTY_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        rx = 1'b1;
  logic        word_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [15:0] resp = 16'h0000;
  logic        tx, word_valid, resp_ready, frame_err, overflow;
  logic [15:0] word;

  int total = 0;
  int bad = 0;

  bitty_uart_host_if #(
    .CLK_DIV(CLK_DIV), .WORD_BYTES(WORD_BYTES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx_i(rx), .tx_o(tx),
    .word_o(word), .word_valid_o(word_valid), .word_ready_i(word_ready),
    .resp_i(resp), .resp_valid_i(resp_valid), .resp_ready_o(resp_ready),
    .frame_err_o(frame_err), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same offset.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    tick(CLK_DIV);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef BITTY_UART_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_v);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[7:0], 1'b1);
    send_byte(w[15:8], 1'b1);
  endtask

  task automatic pop_word(input string tag, input logic [15:0] exp);
    check({tag, "_valid"}, 32'(word_valid), 32'(1));
    check({tag, "_data"}, 32'(word), 32'(exp));
    word_ready = 1'b1;
    tick(1);
    word_ready = 1'b0;
  endtask

  // Expected line level for frame bit b: start 0, data LSB first, optional even parity, stop 1.
  task automatic check_tx(input string tag, input logic [15:0] w);
    int n;
    logic [7:0] byt;
    int pos;
    logic e;
    n = WORD_BYTES * FRAME_BITS;
    check({tag, "_ready_before"}, 32'(resp_ready), 32'(1));
    resp = w;
    resp_valid = 1'b1;
    tick(1);
    resp_valid = 1'b0;
    tick(1);
    for (int b = 0; b < n; b++) begin
      byt = w[8*(b/FRAME_BITS) +: 8];
      pos = b % FRAME_BITS;
      if (pos == 0)      e = 1'b0;
      else if (pos <= 8) e = byt[pos-1];
      else if (pos == 9 && FRAME_BITS == 11) e = ^byt;
      else               e = 1'b1;
      check($sformatf("%s_bit%0d", tag, b), 32'(tx), 32'(e));
      check($sformatf("%s_busy%0d", tag, b), 32'(resp_ready), 32'(0));
      if (b < n - 1) tick(CLK_DIV);
    end
    tick(CLK_DIV - 2);
    check({tag, "_ready_last_stop"}, 32'(resp_ready), 32'(0));
    tick(1);
    check({tag, "_ready_after"}, 32'(resp_ready), 32'(1));
    check({tag, "_idle_line"}, 32'(tx), 32'(1));
  endtask

  initial begin
    // 1: reset and idle
    tick(3);
    rst_n = 1'b1;
    tick(50);
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_valid", 32'(word_valid), 32'(0));
    check("rst_word", 32'(word), 32'h0000);
    check("rst_ready", 32'(resp_ready), 32'(1));
    check("rst_ferr", 32'(frame_err), 32'(0));
    check("rst_ovf", 32'(overflow), 32'(0));

    // 2: single word, little-endian assembly
    send_word(16'h1234);
    pop_word("t2", 16'h1234);
    check("t2_empty", 32'(word_valid), 32'(0));
    check("t2_ferr", 32'(frame_err), 32'(0));
    check("t2_ovf", 32'(overflow), 32'(0));

    // 3: fill FIFO, fifth word overflows
    for (int k = 1; k <= 4; k++) send_word(16'(k));
    check("t3_full_valid", 32'(word_valid), 32'(1));
    check("t3_no_ovf_yet", 32'(overflow), 32'(0));
    send_word(16'h0005);
    check("t3_ovf", 32'(overflow), 32'(1));
    pop_word("t3_w1", 16'h0001);
    pop_word("t3_w2", 16'h0002);
    pop_word("t3_w3", 16'h0003);
    pop_word("t3_w4", 16'h0004);
    check("t3_drained", 32'(word_valid), 32'(0));

    // 4: bad stop bit discards the byte, next word intact
    send_byte(8'h34, 1'b0);
    check("t4_ferr", 32'(frame_err), 32'(1));
    check("t4_nothing", 32'(word_valid), 32'(0));
    send_word(16'hABCD);
    pop_word("t4", 16'hABCD);
    check("t4_single", 32'(word_valid), 32'(0));
    check("t4_ovf_sticky", 32'(overflow), 32'(1));

    // 5: response serialisation, byte 0xEF then 0xBE
    check_tx("t5", 16'hBEEF);

    // ena low: TX forced idle, resp not accepted
    ena = 1'b0;
    tick(1);
    check("ena_ready", 32'(resp_ready), 32'(0));
    check("ena_tx", 32'(tx), 32'(1));
    ena = 1'b1;
    tick(1);
    check("ena_back", 32'(resp_ready), 32'(1));
    resp = 16'h00FF;
    resp_valid = 1'b1;
    tick(1);
    resp_valid = 1'b0;
    tick(1);
    check("ena_start_bit", 32'(tx), 32'(0));
    ena = 1'b0;
    #1;
    check("ena_abort_tx", 32'(tx), 32'(1));
    tick(1);
    ena = 1'b1;
    tick(1);
    check("ena_abort_ready", 32'(resp_ready), 32'(1));
    check("ena_abort_line", 32'(tx), 32'(1));

    // reset mid-frame clears everything at once
    resp = 16'h1111;
    resp_valid = 1'b1;
    tick(1);
    resp_valid = 1'b0;
    tick(1);
    check("mrst_start_bit", 32'(tx), 32'(0));
    rst_n = 1'b0;
    #1;
    check("mrst_tx", 32'(tx), 32'(1));
    check("mrst_ready", 32'(resp_ready), 32'(1));
    check("mrst_ferr", 32'(frame_err), 32'(0));
    check("mrst_ovf", 32'(overflow), 32'(0));
    tick(2);
    rst_n = 1'b1;
    tick(2);

`ifdef BITTY_UART_PARITY_EN
    // 6: parity error on RX, even parity on TX
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i < 2);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("t6_par_ferr", 32'(frame_err), 32'(1));
    check("t6_par_nothing", 32'(word_valid), 32'(0));
    check_tx("t6", 16'h0003);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
